datapath_ctrl: RTL and testbench

Instruction-level controller for the 16-bit, 8-register datapath. It accepts one 16-bit instruction per start handshake, decodes it, and sequences the datapath's control inputs over several cycles: register reads into A/B, shift/ALU selection, C/status loads and register write-back. It sits between the instruction source and the datapath, and drives every datapath control port plus `datapath_in`.

---
 rtl/datapath_ctrl_pkg.sv | 65 ++++++
 rtl/datapath_ctrl_instr_dec.sv | 46 ++++
 rtl/datapath_ctrl.sv | 128 ++++++++++++
 tb/tb_datapath_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared decode constants, state encoding and decoded-instruction types for datapath_ctrl.
// The TRAP state only exists when DATAPATH_CTRL_TRAP_EN is defined.
package datapath_ctrl_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
`ifdef DATAPATH_CTRL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic [1:0] op;
  } fields_t;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic movi;
    logic movr;
    logic add;
    logic cmp;
    logic land;
    logic mvn;
  } cls_t;

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Purely combinational instruction decoder: register fields, sign-extended imm8,
// one-hot class and illegal flag. Field positions assume a 16-bit instruction.
module instr_dec
  import datapath_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_ir,
  output fields_t          o_fld,
  output logic [WIDTH-1:0] o_sximm8,
  output cls_t             o_cls,
  output logic             o_illegal
);

  logic [2:0] w_opc;

  assign w_opc       = i_ir[OPC_HI:OPC_LO];
  assign o_fld.rn    = i_ir[RN_HI:RN_LO];
  assign o_fld.rd    = i_ir[RD_HI:RD_LO];
  assign o_fld.rm    = i_ir[RM_HI:RM_LO];
  assign o_fld.sh    = i_ir[SH_HI:SH_LO];
  assign o_fld.op    = i_ir[OP_HI:OP_LO];
  assign o_sximm8    = {{(WIDTH-8){i_ir[IMM_HI]}}, i_ir[IMM_HI:0]};

  always_comb begin
    o_cls = '0;
    case (w_opc)
      OPC_MOV: begin
        o_cls.movi = (o_fld.op == OP_MOVI);
        o_cls.movr = (o_fld.op == OP_MOVR);
      end
      OPC_ALU: begin
        case (o_fld.op)
          OP_ADD:  o_cls.add  = 1'b1;
          OP_CMP:  o_cls.cmp  = 1'b1;
          OP_AND:  o_cls.land = 1'b1;
          default: o_cls.mvn  = 1'b1;
        endcase
      end
      default: o_cls = '0;
    endcase
  end

  assign o_illegal = (o_cls == '0);

endmodule

// File: rtl/datapath_ctrl.sv
// Instruction-level sequencer for the 16-bit, 8-register datapath (Moore outputs).
// Define DATAPATH_CTRL_TRAP_EN to trap illegal instructions; otherwise they are NOPs.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [WIDTH-1:0] instr,
  output logic             w,
  output logic             err,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic             vsel,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_ir;
  fields_t          w_fld;
  cls_t             w_cls;
  logic             w_illegal;
  logic [WIDTH-1:0] w_sximm8;

  instr_dec #(.WIDTH(WIDTH)) u_dec (
    .i_ir      (r_ir),
    .o_fld     (w_fld),
    .o_sximm8  (w_sximm8),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  // Async reset drops the state to WAIT at once, so any in-flight strobe dies with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT && s) r_ir <= instr;
    end
  end

  assign datapath_in = w_sximm8;

  always_comb begin
    w_state_nxt = r_state;
    w           = 1'b0;
    err         = 1'b0;
    readnum     = 3'd0;
    writenum    = 3'd0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    vsel        = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = 2'b00;
    ALUop       = ALU_ADD;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_illegal) begin
`ifdef DATAPATH_CTRL_TRAP_EN
          w_state_nxt = S_TRAP;
`else
          w_state_nxt = S_WAIT;
`endif
        end else if (w_cls.movi) w_state_nxt = S_WRITE_IMM;
        else if (w_cls.movr || w_cls.mvn) w_state_nxt = S_GET_B;
        else if (w_cls.add || w_cls.cmp || w_cls.land) w_state_nxt = S_GET_A;
        else w_state_nxt = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum    = w_fld.rn;
        vsel        = 1'b1;
        write       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum     = w_fld.rn;
        loada       = 1'b1;
        w_state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum     = w_fld.rm;
        loadb       = 1'b1;
        w_state_nxt = S_ALU;
      end
      S_ALU: begin
        // MOV reg rides the adder with A forced to zero: C = 0 + sh(Rm).
        shift       = w_fld.sh;
        ALUop       = w_cls.movr ? ALU_ADD : w_fld.op;
        asel        = w_cls.movr | w_cls.mvn;
        loads       = w_cls.cmp;
        loadc       = ~w_cls.cmp;
        w_state_nxt = w_cls.cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum    = w_fld.rd;
        write       = 1'b1;
        w_state_nxt = S_WAIT;
      end
`ifdef DATAPATH_CTRL_TRAP_EN
      S_TRAP: err = 1'b1;
`endif
      default: w_state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: the driver pushes the per-cycle control words an
// instruction should produce; a negedge monitor pops one per busy cycle and compares.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        w, err, loada, loadb, loadc, loads, write, vsel, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, aluop;
  logic [15:0] datapath_in;

  datapath_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .instr(instr),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .vsel(vsel), .asel(asel), .bsel(bsel), .shift(shift), .ALUop(aluop),
    .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w, err;
    logic [2:0]  readnum, writenum;
    logic        loada, loadb, loadc, loads, write, vsel, asel, bsel;
    logic [1:0]  shift, aluop;
    logic [15:0] din;
  } obs_t;

  obs_t        act;
  obs_t        exp_q[$];
  logic [15:0] m_ir = 16'h0;
  int          vec = 0;
  int          errs = 0;
  bit          run = 1'b0;

  assign act = {w, err, readnum, writenum, loada, loadb, loadc, loads, write,
                vsel, asel, bsel, shift, aluop, datapath_in};

  function automatic obs_t base_word(input logic [15:0] ir);
    obs_t b = '0;
    b.din = {{8{ir[7]}}, ir[7:0]};
    return b;
  endfunction

  function automatic obs_t idle_word(input logic [15:0] ir);
    obs_t b = base_word(ir);
    b.w = 1'b1;
    return b;
  endfunction

  task automatic check(input obs_t e, input string name);
    vec++;
    if (act !== e) begin
      errs++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, e);
    end
  endtask

  // Reference: instruction -> list of control words, one per busy cycle.
  function automatic int push_expect(input logic [15:0] ir);
    logic [2:0] opc = ir[15:13];
    logic [1:0] op  = ir[12:11];
    bit movi, movr, add, cmp, andi, mvn;
    obs_t b = base_word(ir);
    obs_t t;
    int   n = 0;
    movi = (opc == 3'b110) && (op == 2'b10);
    movr = (opc == 3'b110) && (op == 2'b00);
    add  = (opc == 3'b101) && (op == 2'b00);
    cmp  = (opc == 3'b101) && (op == 2'b01);
    andi = (opc == 3'b101) && (op == 2'b10);
    mvn  = (opc == 3'b101) && (op == 2'b11);
    exp_q.push_back(b); n++;
    if (movi) begin
      t = b; t.writenum = ir[10:8]; t.vsel = 1'b1; t.write = 1'b1;
      exp_q.push_back(t); n++;
    end else if (movr || add || cmp || andi || mvn) begin
      if (add || cmp || andi) begin
        t = b; t.readnum = ir[10:8]; t.loada = 1'b1;
        exp_q.push_back(t); n++;
      end
      t = b; t.readnum = ir[2:0]; t.loadb = 1'b1;
      exp_q.push_back(t); n++;
      t = b; t.shift = ir[4:3];
      t.aluop = movr ? 2'b00 : op;
      t.asel  = movr || mvn;
      t.loads = cmp;
      t.loadc = !cmp;
      exp_q.push_back(t); n++;
      if (!cmp) begin
        t = b; t.writenum = ir[7:5]; t.write = 1'b1;
        exp_q.push_back(t); n++;
      end
    end
`ifdef DATAPATH_CTRL_TRAP_EN
    else begin
      t = b; t.err = 1'b1;
      repeat (3) begin exp_q.push_back(t); n++; end
    end
`endif
    return n;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      if (w === 1'b1) begin
        if (exp_q.size() != 0) begin
          vec++; errs++;
          $display("FAIL early_idle at %0t: got w=1 expected %0d more busy cycles", $time, exp_q.size());
          exp_q.delete();
        end
        check(idle_word(m_ir), "idle");
      end else if (exp_q.size() == 0) begin
        vec++; errs++;
        $display("FAIL unexpected_busy at %0t: got %h expected w=1", $time, act);
      end else begin
        check(exp_q.pop_front(), "busy");
      end
    end
  end

  // Called at posedge+1 with the DUT in WAIT; returns at posedge+1 of the edge back into WAIT.
  task automatic issue(input logic [15:0] ir, input bit hold_s);
    int n;
    s = 1'b1; instr = ir;
    @(posedge clk); #1;
    m_ir = ir;
    n = push_expect(ir);
    repeat (n) begin
      s = hold_s ? 1'b1 : 1'($urandom_range(0, 1));
      instr = 16'($urandom);
      @(posedge clk); #1;
    end
    s = 1'b0;
  endtask

  task automatic idle(input int k);
    s = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s = 1'b0;
    exp_q.delete();
    m_ir = 16'h0;
    #1;
    check(idle_word(16'h0), "async_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 7))
      0, 1, 2: begin r[15:13] = 3'b110; r[12] = 1'b0; end
      3, 4, 5, 6: r[15:13] = 3'b101;
      default: begin
`ifdef DATAPATH_CTRL_TRAP_EN
        r[15:13] = 3'b101;
`endif
      end
    endcase
    return r;
  endfunction

  initial begin
    int n;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);

    issue(16'hD3FE, 1'b0);       // MOV R3,#-2
    idle(2);
    issue(16'hA148, 1'b0);       // ADD R2,R1,R0 LSL1
    issue(16'hAD05, 1'b0);       // CMP R5,R5, back-to-back
    issue(16'hB8E4, 1'b1);       // MVN R7,R4 with s held high
    issue(16'hC0E9, 1'b1);       // MOV R7,R1 LSL1 accepted after one WAIT cycle
    idle(1);

`ifdef DATAPATH_CTRL_TRAP_EN
    s = 1'b1; instr = 16'hE000;
    @(posedge clk); #1;
    m_ir = 16'hE000;
    n = push_expect(16'hE000);
    s = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    do_reset();
`else
    issue(16'hE000, 1'b0);
    idle(1);
`endif

    // Reset lands in GET_B of an ADD: only DECODE and GET_A are ever observed.
    s = 1'b1; instr = 16'hA36B;
    @(posedge clk); #1;
    m_ir = 16'hA36B;
    n = push_expect(16'hA36B);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();

    repeat (80) begin
      issue(rand_instr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    run = 1'b0;
    vec++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL leftover: got %0d unconsumed words expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
